// File: rtl/fp_arith.sv
// Binary32 adder and multiplier sharing operands, round-to-nearest-even, flush-to-zero.
// Define FP_ARITH_PIPELINE_EN for the 4-stage pipeline; otherwise a single output register.
module fp_arith (
    input  logic        clk,
    input  logic        sclr,
    input  logic        ADD_SUB,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_Z_ADD,
    output logic [31:0] FP_Z_MUL
);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_val;
        logic        sa;
        logic [7:0]  ea;
        logic [23:0] ma;
        logic        sb;
        logic [7:0]  eb;
        logic [23:0] mb;
    } add_s1_t;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_val;
        logic        sign;
        logic [7:0]  ea;
        logic [23:0] ma;
        logic [7:0]  eb;
        logic [23:0] mb;
    } mul_s1_t;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_val;
        logic        sign;
        logic        eff_sub;
        logic        zsign;
        logic [7:0]  exp;
        logic [26:0] ml;
        logic [26:0] ms;
    } add_s2_t;

    typedef struct packed {
        logic        spec;
        logic [31:0] spec_val;
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
    } mul_s2_t;

    // Normalised value: mant[26] hidden bit, [25:3] fraction, [2] guard, [1:0] round/sticky.
    typedef struct packed {
        logic        spec;
        logic [31:0] spec_val;
        logic        sign;
        logic        zero;
        logic [9:0]  exp;
        logic [26:0] mant;
    } norm_t;

    // Returns {nan, inf, zero}; denormals classify as zero.
    function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [2:0] c;
        c[2] = (e == 8'hFF) && (f != 23'h0);
        c[1] = (e == 8'hFF) && (f == 23'h0);
        c[0] = (e == 8'h00);
        return c;
    endfunction

    function automatic add_s1_t add_unpack(input logic [31:0] a, input logic [31:0] b,
                                           input logic add_sub);
        add_s1_t    r;
        logic [2:0] ca;
        logic [2:0] cb;
        logic       sb;
        ca = classify(a[30:23], a[22:0]);
        cb = classify(b[30:23], b[22:0]);
        sb = b[31] ^ ~add_sub;
        r.spec = ca[2] | cb[2] | ca[1] | cb[1];
        if (ca[2] || cb[2] || (ca[1] && cb[1] && (a[31] != sb)))
            r.spec_val = QNAN;
        else if (ca[1])
            r.spec_val = {a[31], INF_MAG};
        else
            r.spec_val = {sb, INF_MAG};
        r.sa = a[31];
        r.ea = ca[0] ? 8'h00 : a[30:23];
        r.ma = ca[0] ? 24'h0 : {1'b1, a[22:0]};
        r.sb = sb;
        r.eb = cb[0] ? 8'h00 : b[30:23];
        r.mb = cb[0] ? 24'h0 : {1'b1, b[22:0]};
        return r;
    endfunction

    function automatic mul_s1_t mul_unpack(input logic [31:0] a, input logic [31:0] b);
        mul_s1_t    r;
        logic [2:0] ca;
        logic [2:0] cb;
        ca = classify(a[30:23], a[22:0]);
        cb = classify(b[30:23], b[22:0]);
        r.sign = a[31] ^ b[31];
        r.spec = ca[2] | cb[2] | ca[1] | cb[1];
        if (ca[2] || cb[2] || (ca[1] && cb[0]) || (ca[0] && cb[1]))
            r.spec_val = QNAN;
        else
            r.spec_val = {r.sign, INF_MAG};
        r.ea = ca[0] ? 8'h00 : a[30:23];
        r.ma = ca[0] ? 24'h0 : {1'b1, a[22:0]};
        r.eb = cb[0] ? 8'h00 : b[30:23];
        r.mb = cb[0] ? 24'h0 : {1'b1, b[22:0]};
        return r;
    endfunction

    // Larger magnitude first; smaller shifted right with bits lost OR-ed into sticky.
    function automatic add_s2_t add_align(input add_s1_t s);
        add_s2_t     r;
        logic        swap;
        logic [7:0]  el;
        logic [7:0]  es;
        logic [7:0]  diff;
        logic [23:0] ml;
        logic [23:0] ms;
        logic [26:0] ms_x;
        logic [26:0] mask;
        swap = {s.eb, s.mb} > {s.ea, s.ma};
        el   = swap ? s.eb : s.ea;
        es   = swap ? s.ea : s.eb;
        ml   = swap ? s.mb : s.ma;
        ms   = swap ? s.ma : s.mb;
        diff = el - es;
        ms_x = {ms, 3'b000};
        mask = '0;
        r.spec     = s.spec;
        r.spec_val = s.spec_val;
        r.sign     = swap ? s.sb : s.sa;
        r.eff_sub  = s.sa ^ s.sb;
        r.zsign    = s.sa & s.sb;
        r.exp      = el;
        r.ml       = {ml, 3'b000};
        if (diff >= 8'd27) begin
            r.ms = {26'h0, |ms};
        end else begin
            mask = (27'd1 << diff) - 27'd1;
            r.ms = (ms_x >> diff) | {26'h0, |(ms_x & mask)};
        end
        return r;
    endfunction

    function automatic mul_s2_t mul_mult(input mul_s1_t s);
        mul_s2_t r;
        r.spec     = s.spec;
        r.spec_val = s.spec_val;
        r.sign     = s.sign;
        r.exp      = 10'({2'b00, s.ea}) + 10'({2'b00, s.eb}) - 10'd127;
        r.prod     = 48'(s.ma) * 48'(s.mb);
        return r;
    endfunction

    function automatic norm_t add_norm(input add_s2_t s);
        norm_t             r;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        sum = s.eff_sub ? ({1'b0, s.ml} - {1'b0, s.ms}) : ({1'b0, s.ml} + {1'b0, s.ms});
        e   = $signed({2'b00, s.exp});
        lz  = '0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        r.spec     = s.spec;
        r.spec_val = s.spec_val;
        r.zero     = (sum == 28'h0);
        r.sign     = r.zero ? s.zsign : s.sign;
        if (sum[27]) begin
            r.mant = {sum[27:2], sum[1] | sum[0]};
            r.exp  = 10'(e + 10'sd1);
        end else begin
            r.mant = sum[26:0] << lz;
            r.exp  = 10'(e - $signed({5'b00000, lz}));
        end
        return r;
    endfunction

    function automatic norm_t mul_norm(input mul_s2_t s);
        norm_t r;
        r.spec     = s.spec;
        r.spec_val = s.spec_val;
        r.sign     = s.sign;
        r.zero     = (s.prod == 48'h0);
        if (s.prod[47]) begin
            r.mant = {s.prod[47:22], |s.prod[21:0]};
            r.exp  = s.exp + 10'd1;
        end else begin
            r.mant = {s.prod[46:21], |s.prod[20:0]};
            r.exp  = s.exp;
        end
        return r;
    endfunction

    // Round to nearest even, then saturate to Inf or flush to signed zero.
    function automatic logic [31:0] round_pack(input norm_t n);
        logic              rnd;
        logic [24:0]       m25;
        logic [22:0]       frac;
        logic signed [9:0] e;
        logic [31:0]       z;
        rnd = n.mant[2] & (n.mant[3] | n.mant[1] | n.mant[0]);
        m25 = {1'b0, n.mant[26:3]} + 25'(rnd);
        e   = $signed(n.exp);
        if (m25[24]) begin
            e    = e + 10'sd1;
            frac = m25[23:1];
        end else begin
            frac = m25[22:0];
        end
        if (n.spec)
            z = n.spec_val;
        else if (n.zero || e <= 10'sd0)
            z = {n.sign, 31'h0};
        else if (e >= 10'sd255)
            z = {n.sign, INF_MAG};
        else
            z = {n.sign, 8'(e), frac};
        return z;
    endfunction

`ifdef FP_ARITH_PIPELINE_EN
    add_s1_t add_s1;
    mul_s1_t mul_s1;
    add_s2_t add_s2;
    mul_s2_t mul_s2;
    norm_t   add_s3;
    norm_t   mul_s3;

    // Unpack -> align/multiply -> add/normalise -> round/pack.
    always_ff @(posedge clk) begin
        if (sclr) begin
            add_s1   <= '0;
            mul_s1   <= '0;
            add_s2   <= '0;
            mul_s2   <= '0;
            add_s3   <= '0;
            mul_s3   <= '0;
            FP_Z_ADD <= '0;
            FP_Z_MUL <= '0;
        end else begin
            add_s1   <= add_unpack(FP_A, FP_B, ADD_SUB);
            mul_s1   <= mul_unpack(FP_A, FP_B);
            add_s2   <= add_align(add_s1);
            mul_s2   <= mul_mult(mul_s1);
            add_s3   <= add_norm(add_s2);
            mul_s3   <= mul_norm(mul_s2);
            FP_Z_ADD <= round_pack(add_s3);
            FP_Z_MUL <= round_pack(mul_s3);
        end
    end
`else
    // Same stage functions chained combinationally into the output register.
    always_ff @(posedge clk) begin
        if (sclr) begin
            FP_Z_ADD <= '0;
            FP_Z_MUL <= '0;
        end else begin
            FP_Z_ADD <= round_pack(add_norm(add_align(add_unpack(FP_A, FP_B, ADD_SUB))));
            FP_Z_MUL <= round_pack(mul_norm(mul_mult(mul_unpack(FP_A, FP_B))));
        end
    end
`endif

endmodule

// File: tb/tb_fp_arith.sv
// Directed vector bench for fp_arith; latency follows FP_ARITH_PIPELINE_EN.
module tb_fp_arith;

`ifdef FP_ARITH_PIPELINE_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned NV = 20;

    typedef struct packed {
        logic        add_sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z_add;
        logic [31:0] z_mul;
    } vec_t;

    logic        clk = 1'b0;
    logic        sclr;
    logic        add_sub;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic [31:0] z_add;
    logic [31:0] z_mul;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_err = 0;

    fp_arith dut (
        .clk      (clk),
        .sclr     (sclr),
        .ADD_SUB  (add_sub),
        .FP_A     (fp_a),
        .FP_B     (fp_b),
        .FP_Z_ADD (z_add),
        .FP_Z_MUL (z_mul)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        add_sub = v.add_sub;
        fp_a    = v.a;
        fp_b    = v.b;
    endtask

    initial begin
        // {add_sub, a, b, expected sum/difference, expected product}
        vecs[0]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
        vecs[1]  = '{1'b0, 32'h3FC00000, 32'h40000000, 32'hBF000000, 32'h40400000};
        vecs[2]  = '{1'b1, 32'h12345678, 32'h9ABCDEF1, 32'h9ABCDE97, 32'h80000000};
        vecs[3]  = '{1'b0, 32'h12345678, 32'h9ABCDEF1, 32'h1ABCDF4B, 32'h80000000};
        vecs[4]  = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7FC00000};
        vecs[5]  = '{1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFF800000};
        vecs[6]  = '{1'b1, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 32'h7F800000};
        vecs[7]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000};
        vecs[8]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
        vecs[9]  = '{1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000};
        vecs[10] = '{1'b1, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000};
        vecs[11] = '{1'b1, 32'h7F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000};
        vecs[12] = '{1'b1, 32'h00000001, 32'h3F800000, 32'h3F800000, 32'h00000000};
        vecs[13] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h33800000};
        vecs[14] = '{1'b1, 32'h3F800000, 32'h34400000, 32'h3F800002, 32'h34400000};
        vecs[15] = '{1'b1, 32'h3F800001, 32'h3F800001, 32'h40000001, 32'h3F800002};
        vecs[16] = '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000};
        vecs[17] = '{1'b0, 32'h3F800001, 32'h3F800000, 32'h34000000, 32'h3F800001};
        vecs[18] = '{1'b0, 32'h00800001, 32'h00800000, 32'h00000000, 32'h00000000};
        vecs[19] = '{1'b0, 32'hC0400000, 32'h3FC00000, 32'hC0900000, 32'hC0900000};

        sclr    = 1'b1;
        add_sub = 1'b0;
        fp_a    = 32'h3F800000;
        fp_b    = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        check("reset add", z_add, 32'h0);
        check("reset mul", z_mul, 32'h0);

        // Back-to-back stream: vector k sampled at edge k, result after edge k+LAT-1.
        sclr = 1'b0;
        drive(vecs[0]);
        for (int k = 0; k < int'(NV + LAT) - 1; k++) begin
            @(posedge clk);
            #1;
            if (k - int'(LAT) + 1 >= 0) begin
                check($sformatf("vec%0d add", k - int'(LAT) + 1), z_add, vecs[k - int'(LAT) + 1].z_add);
                check($sformatf("vec%0d mul", k - int'(LAT) + 1), z_mul, vecs[k - int'(LAT) + 1].z_mul);
            end
            if (k + 1 < int'(NV)) drive(vecs[k + 1]);
        end

        // Operands held steady: outputs settle and stay put.
        drive(vecs[2]);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c >= int'(LAT)) begin
                check($sformatf("hold%0d add", c), z_add, vecs[2].z_add);
                check($sformatf("hold%0d mul", c), z_mul, vecs[2].z_mul);
            end
        end

        // Four-set stream with sclr pulsed on the third edge.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        drive(vecs[1]);
        @(posedge clk);
        #1;
        drive(vecs[19]);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        check("midrst add", z_add, 32'h0);
        check("midrst mul", z_mul, 32'h0);
        drive(vecs[15]);
        sclr = 1'b0;
        for (int e = 3; e < 3 + int'(LAT); e++) begin
            @(posedge clk);
            #1;
            if (e == 2 + int'(LAT)) begin
                check("postrst add", z_add, vecs[15].z_add);
                check("postrst mul", z_mul, vecs[15].z_mul);
            end else begin
                check($sformatf("flush%0d add", e), z_add, 32'h0);
                check($sformatf("flush%0d mul", e), z_mul, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_arith.md
FP_ARITH -- requirements
Module: fp_arith

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: sclr  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port: ADD_SUB  in  1  1 = FP_A+FP_B, 0 = FP_A-FP_B; applies to the adder only.
REQ-004 SHALL have port: FP_A  in  32  IEEE-754 binary32 operand A, shared by adder and multiplier.
REQ-005 SHALL have port: FP_B  in  32  IEEE-754 binary32 operand B, shared by adder and multiplier.
REQ-006 SHALL have port: FP_Z_ADD  out  32  registered binary32 sum/difference.
REQ-007 SHALL have port: FP_Z_MUL  out  32  registered binary32 product.
REQ-008 SHALL have no parameters and no handshake: every cycle accepts a new operand set, and each result appears a fixed latency later.

Function
REQ-009 SHALL compute FP_Z_ADD = round(FP_A ± FP_B) and FP_Z_MUL = round(FP_A × FP_B), both round-to-nearest-even.
- FP_B sign is inverted when ADD_SUB = 0.
REQ-010 SHALL use a 24-bit significand with hidden bit, plus guard, round and sticky bits for alignment and normalisation.
REQ-011 SHALL flush denormal inputs to signed zero; a denormal or underflowed result SHALL become signed zero (sign = computed sign).
REQ-012 SHALL saturate exponent overflow to ±Inf (0x7F800000 / 0xFF800000).
REQ-013 SHALL handle special values as follows:
- NaN on any input, Inf-Inf, or Inf×0 -> canonical NaN 0x7FC00000.
- Inf op finite -> Inf with the correct sign.
REQ-014 SHALL produce an exact-zero sum as +0, except (-0)+(-0) = -0.
REQ-015 SHALL make the adder and multiplier independent, equal-latency datapaths; FP_Z_ADD and FP_Z_MUL for operands sampled at edge N SHALL be valid after the same edge.
REQ-016 SHALL let results be a pure function of the sampled inputs: identical inputs give bit-identical outputs in both configurations.

Reset
REQ-017 SHALL, while sclr = 1 at a rising edge, clear all pipeline/output registers; FP_Z_ADD = FP_Z_MUL = 0x00000000 from the next cycle.
REQ-018 SHALL, when sclr is asserted mid-operation, discard in-flight operations; after release, outputs stay 0 until the first post-reset operand set reaches the output.
REQ-019 SHALL take the first operand set on the first edge with sclr = 0.

Configuration
REQ-020 SHALL, with macro FP_ARITH_PIPELINE_EN defined, use a 4-stage pipeline for both datapaths:
- stages: unpack/special-detect, align/multiply, add/normalise, round/pack.
- latency 4 cycles; throughput 1 per cycle.
REQ-021 SHALL, without FP_ARITH_PIPELINE_EN, compute both datapaths combinationally into a single output register.
- latency 1 cycle.
- results bit-identical to the pipelined build.

Verification
REQ-022 SHALL cover: FP_A = 0x3F800000, FP_B = 0x3F800000, ADD_SUB = 1 -> FP_Z_ADD = 0x40000000, FP_Z_MUL = 0x3F800000 after the configured latency.
REQ-023 SHALL cover: FP_A = 0x3FC00000, FP_B = 0x40000000 -> FP_Z_MUL = 0x40400000; with ADD_SUB = 0 -> FP_Z_ADD = 0xBF000000.
REQ-024 SHALL cover: FP_A = 0x12345678, FP_B = 0x9ABCDEF1 held 12 cycles, ADD_SUB = 1 -> FP_Z_ADD = 0x9ABCDE97, FP_Z_MUL = 0x80000000 (underflow flush).
- With ADD_SUB = 0 -> FP_Z_ADD = 0x1ABCDF4B.
- Both builds give identical outputs.
REQ-025 SHALL cover: FP_A = 0x7F800000, FP_B = 0x00000000 -> FP_Z_MUL = 0x7FC00000; with FP_B = 0xFF800000 and ADD_SUB = 1 -> FP_Z_ADD = 0x7FC00000.
REQ-026 SHALL cover: FP_A = 0x7F7FFFFF, FP_B = 0x40000000 -> FP_Z_MUL = 0x7F800000.
REQ-027 SHALL cover: a back-to-back stream of 4 operand sets with sclr pulsed at cycle 2 -> outputs 0x00000000 the cycle after reset, and only post-reset operand sets produce results, at the configured latency.
